// File: rtl/prio_intr_pkg.sv
// Shared types, limits and sizing helpers for the priority interrupt controller.
package prio_intr_pkg;

    localparam int unsigned NUM_CH_MIN = 2;
    localparam int unsigned NUM_CH_MAX = 64;
    localparam int unsigned NUM_CH_DEF = 9;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    // Channel ID width, never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/prio_arbiter.sv
// Combinational arbiter: fixed priority (index 0 first) or round-robin from ptr,
// built as a double-width rotate followed by a find-first-set.
module prio_arbiter
    import prio_intr_pkg::*;
#(
    parameter  int unsigned NUM_CH = NUM_CH_DEF,
    localparam int unsigned ID_W   = id_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] elig,
    input  logic [ID_W-1:0]   ptr,
    input  logic              rr_mode,
    output logic [ID_W-1:0]   winner,
    output logic              any_valid
);

    localparam logic [ID_W:0] NUM_CH_W = (ID_W + 1)'(NUM_CH);

    logic [ID_W-1:0]   base;
    logic [NUM_CH-1:0] rot;
    logic [ID_W-1:0]   offs;
    logic [ID_W:0]     sum;

    always_comb begin
        base = rr_mode ? ptr : '0;
        rot  = NUM_CH'({elig, elig} >> base);

        // Descending scan so the lowest set offset is the one left standing.
        offs = '0;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            if (rot[i]) begin
                offs = ID_W'(i);
            end
        end

        // base < NUM_CH and offs < NUM_CH, so one conditional subtract wraps.
        sum = {1'b0, base} + {1'b0, offs};
        if (sum >= NUM_CH_W) begin
            sum = sum - NUM_CH_W;
        end

        winner    = ID_W'(sum);
        any_valid = |elig;
    end

endmodule

// File: rtl/prio_intr_ctrl.sv
// Priority interrupt controller: registered request edge detect, sticky pending
// bits with masking, fixed/round-robin arbitration and an irq/ack handshake.
module prio_intr_ctrl
    import prio_intr_pkg::*;
#(
    parameter  int unsigned NUM_CH = NUM_CH_DEF,
    localparam int unsigned ID_W   = id_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] req_in,
    input  logic [NUM_CH-1:0] mask_in,
    input  logic              rr_mode,
    input  logic              ack,
    output logic              irq,
    output logic [ID_W-1:0]   irq_id,
    output logic [NUM_CH-1:0] pend_out
);

    localparam logic [ID_W:0] NUM_CH_W = (ID_W + 1)'(NUM_CH);

    state_e            state_q, state_d;
    logic [NUM_CH-1:0] req_sync_q, req_sync_d;
    logic [NUM_CH-1:0] req_prev_q, req_prev_d;
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [NUM_CH-1:0] pend_out_q, pend_out_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic              irq_q, irq_d;
    logic [ID_W-1:0]   irq_id_q, irq_id_d;

    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] clr;
    logic [NUM_CH-1:0] elig;
    logic [ID_W-1:0]   winner;
    logic              any_valid;
    logic [ID_W:0]     id_inc;

    prio_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arbiter (
        .elig      (elig),
        .ptr       (ptr_q),
        .rr_mode   (rr_mode),
        .winner    (winner),
        .any_valid (any_valid)
    );

    // Input capture, edge detect and pending bookkeeping; a new rise beats a clear.
    always_comb begin
        req_sync_d = req_in;
        req_prev_d = req_sync_q;
        rise       = req_sync_q & ~req_prev_q;
        pend_d     = (pend_q & ~clr) | rise;
        pend_out_d = pend_q;
        elig       = pend_q & ~mask_in;
    end

    // Handshake FSM: the presented ID stays frozen in HOLD until acknowledged.
    always_comb begin
        state_d  = state_q;
        irq_d    = irq_q;
        irq_id_d = irq_id_q;
        ptr_d    = ptr_q;
        clr      = '0;
        id_inc   = {1'b0, irq_id_q} + (ID_W + 1)'(1);

        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    irq_d    = 1'b1;
                    irq_id_d = winner;
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                if (ack) begin
                    clr     = NUM_CH'(1) << irq_id_q;
                    irq_d   = 1'b0;
                    ptr_d   = (id_inc == NUM_CH_W) ? '0 : ID_W'(id_inc);
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            req_sync_q <= '0;
            req_prev_q <= '0;
            pend_q     <= '0;
            pend_out_q <= '0;
            ptr_q      <= '0;
            irq_q      <= 1'b0;
            irq_id_q   <= '0;
        end else begin
            state_q    <= state_d;
            req_sync_q <= req_sync_d;
            req_prev_q <= req_prev_d;
            pend_q     <= pend_d;
            pend_out_q <= pend_out_d;
            ptr_q      <= ptr_d;
            irq_q      <= irq_d;
            irq_id_q   <= irq_id_d;
        end
    end

    assign irq      = irq_q;
    assign irq_id   = irq_id_q;
    assign pend_out = pend_out_q;

endmodule
